// File: rtl/pipe_rca_adder.sv
// Segmented pipelined ripple-carry adder: S/COUT = A + B + CIN, built from fa cells.
// Latency NSEG cycles (counted in EN=1 edges), one new operation accepted per EN=1 cycle.
// No backpressure beyond EN: EN=0 freezes every register, including skew and valid bits.

// Single-bit full adder cell used to build each segment's ripple chain.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module pipe_rca_adder #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OUT_VALID
);
    localparam int NSEG = WIDTH / SEG;

    if (WIDTH % SEG != 0) begin : g_bad_seg
        $error("pipe_rca_adder: WIDTH must be a multiple of SEG");
    end

    // w_cin[k]/w_vpipe[k]: carry-in and valid seen by stage k in the current cycle.
    logic [NSEG-1:0]  w_cin;
    logic [NSEG-1:0]  w_cout;
    logic [NSEG-1:0]  w_vpipe;
    logic [WIDTH-1:0] w_sum_final;

    assign w_cin[0]   = CIN;
    assign w_vpipe[0] = IN_VALID;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG-1:0] w_a;
        logic [SEG-1:0] w_b;
        logic [SEG-1:0] w_s;
        logic [SEG:0]   w_c;

        if (k == 0) begin : g_noskew
            assign w_a = A[SEG-1:0];
            assign w_b = B[SEG-1:0];
        end else begin : g_skew
            // Operand slice k waits k cycles so it meets the carry from stage k-1.
            logic [SEG-1:0] r_a_sk [k];
            logic [SEG-1:0] r_b_sk [k];

            // Input skew shift register for this segment's operand slice.
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    for (int i = 0; i < k; i++) begin
                        r_a_sk[i] <= '0;
                        r_b_sk[i] <= '0;
                    end
                end else if (EN) begin
                    r_a_sk[0] <= A[k*SEG +: SEG];
                    r_b_sk[0] <= B[k*SEG +: SEG];
                    for (int i = 1; i < k; i++) begin
                        r_a_sk[i] <= r_a_sk[i-1];
                        r_b_sk[i] <= r_b_sk[i-1];
                    end
                end
            end

            assign w_a = r_a_sk[k-1];
            assign w_b = r_b_sk[k-1];
        end

        // Ripple chain of SEG full adders.
        assign w_c[0] = w_cin[k];
        for (genvar j = 0; j < SEG; j++) begin : g_bit
            fa u_fa (
                .i_a (w_a[j]),
                .i_b (w_b[j]),
                .i_c (w_c[j]),
                .o_s (w_s[j]),
                .o_c (w_c[j+1])
            );
        end
        assign w_cout[k] = w_c[SEG];

        if (k < NSEG - 1) begin : g_mid
            localparam int D = NSEG - 1 - k;
            logic [SEG-1:0] r_s_dk [D];
            logic           r_cy;
            logic           r_v;

            // Segment carry/valid hand-off to the next stage, plus sum deskew so all
            // slices of one operation reach the output register together.
            always_ff @(posedge CLK) begin
                if (!RSTN) begin
                    r_cy <= 1'b0;
                    r_v  <= 1'b0;
                    for (int i = 0; i < D; i++) r_s_dk[i] <= '0;
                end else if (EN) begin
                    r_cy      <= w_c[SEG];
                    r_v       <= w_vpipe[k];
                    r_s_dk[0] <= w_s;
                    for (int i = 1; i < D; i++) r_s_dk[i] <= r_s_dk[i-1];
                end
            end

            assign w_cin[k+1]              = r_cy;
            assign w_vpipe[k+1]            = r_v;
            assign w_sum_final[k*SEG +: SEG] = r_s_dk[D-1];
        end else begin : g_last
            // Last segment's sum and carry-out go straight into the output register.
            assign w_sum_final[k*SEG +: SEG] = w_s;
        end
    end

    // Output register: loads only when a valid result emerges; otherwise holds.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            S         <= '0;
            COUT      <= 1'b0;
            OUT_VALID <= 1'b0;
        end else if (EN) begin
            OUT_VALID <= w_vpipe[NSEG-1];
            if (w_vpipe[NSEG-1]) begin
                S    <= w_sum_final;
                COUT <= w_cout[NSEG-1];
            end
        end
    end
endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed-vector bench for pipe_rca_adder at WIDTH=32, SEG=8 (latency 4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Each scenario task carries its own expected values and comparisons.
module tb_pipe_rca_adder;
    logic        CLK;
    logic        RSTN;
    logic        EN;
    logic        IN_VALID;
    logic [31:0] A;
    logic [31:0] B;
    logic        CIN;
    logic [31:0] S;
    logic        COUT;
    logic        OUT_VALID;

    int checks   = 0;
    int failures = 0;

    pipe_rca_adder #(.WIDTH(32), .SEG(8)) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .EN        (EN),
        .IN_VALID  (IN_VALID),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .S         (S),
        .COUT      (COUT),
        .OUT_VALID (OUT_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
        IN_VALID = v;
        A        = a;
        B        = b;
        CIN      = c;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        EN   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, $urandom, $urandom, 1'b1);
            tick();
            checks++;
            if ({OUT_VALID, COUT, S} !== 34'h0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d: got v=%b c=%b s=%h expected all zero", c, OUT_VALID, COUT, S);
            end
        end
        RSTN = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({OUT_VALID, COUT, S} !== 34'h0) begin
                failures++;
                $display("FAIL reset_after cyc%0d: got v=%b c=%b s=%h expected all zero", c, OUT_VALID, COUT, S);
            end
        end
    endtask

    task automatic test_full_ripple();
        for (int c = 0; c < 6; c++) begin
            if (c == 0) drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
            else        drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            checks++;
            if (OUT_VALID !== (c == 3)) begin
                failures++;
                $display("FAIL ripple_valid cyc%0d: got %b expected %b", c, OUT_VALID, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (S !== 32'h0000_0000 || COUT !== 1'b1) begin
                    failures++;
                    $display("FAIL ripple_sum: got c=%b s=%h expected c=1 s=00000000", COUT, S);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic        tc [3];
        logic [31:0] es [3];
        logic        ec [3];
        logic        exp_v;
        ta = '{32'h1234_5678, 32'h8000_0000, 32'h00FF_00FF};
        tb = '{32'h1111_1111, 32'h8000_0000, 32'h0001_FF01};
        tc = '{1'b0, 1'b1, 1'b0};
        es = '{32'h2345_6789, 32'h0000_0001, 32'h0101_0000};
        ec = '{1'b0, 1'b1, 1'b0};
        for (int c = 0; c < 8; c++) begin
            if (c < 3) drive(1'b1, ta[c], tb[c], tc[c]);
            else       drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            exp_v = (c >= 3 && c < 6);
            checks++;
            if (OUT_VALID !== exp_v) begin
                failures++;
                $display("FAIL b2b_valid cyc%0d: got %b expected %b", c, OUT_VALID, exp_v);
            end
            if (exp_v) begin
                checks++;
                if (S !== es[c-3] || COUT !== ec[c-3]) begin
                    failures++;
                    $display("FAIL b2b_sum op%0d: got c=%b s=%h expected c=%b s=%h", c-3, COUT, S, ec[c-3], es[c-3]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] ta [3];
        logic [31:0] tb [3];
        logic        tc [3];
        logic [31:0] es [3];
        logic        ec [3];
        logic        exp_v;
        int          op;
        int          pulses;
        ta = '{32'h1234_5678, 32'h8000_0000, 32'h00FF_00FF};
        tb = '{32'h1111_1111, 32'h8000_0000, 32'h0001_FF01};
        tc = '{1'b0, 1'b1, 1'b0};
        es = '{32'h2345_6789, 32'h0000_0001, 32'h0101_0000};
        ec = '{1'b0, 1'b1, 1'b0};
        pulses = 0;
        // EN edges: c0,c1 issue ops 0,1; c2..c4 stalled; c5 issues op 2.
        for (int c = 0; c < 11; c++) begin
            EN = !(c >= 2 && c <= 4);
            if (c < 2)       drive(1'b1, ta[c], tb[c], tc[c]);
            else if (c <= 4) drive(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1);
            else if (c == 5) drive(1'b1, ta[2], tb[2], tc[2]);
            else             drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            exp_v = (c >= 6 && c <= 8);
            checks++;
            if (OUT_VALID !== exp_v) begin
                failures++;
                $display("FAIL stall_valid cyc%0d: got %b expected %b", c, OUT_VALID, exp_v);
            end
            if (exp_v) begin
                op = c - 6;
                pulses++;
                checks++;
                if (S !== es[op] || COUT !== ec[op]) begin
                    failures++;
                    $display("FAIL stall_sum op%0d: got c=%b s=%h expected c=%b s=%h", op, COUT, S, ec[op], es[op]);
                end
            end
        end
        EN = 1'b1;
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL stall_pulses: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_bubble();
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(1'b1, 32'h0000_0005, 32'h0000_0003, 1'b0);
            else if (c == 1) drive(1'b0, 32'h5555_AAAA, 32'h1234_4321, 1'b1);
            else if (c == 2) drive(1'b1, 32'hFFFF_0000, 32'h0001_0000, 1'b0);
            else             drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            checks++;
            if (OUT_VALID !== (c == 3 || c == 5)) begin
                failures++;
                $display("FAIL bubble_valid cyc%0d: got %b expected %b", c, OUT_VALID, (c == 3 || c == 5));
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (S !== 32'h0000_0008 || COUT !== 1'b0) begin
                    failures++;
                    $display("FAIL bubble_first cyc%0d: got c=%b s=%h expected c=0 s=00000008", c, COUT, S);
                end
            end
            if (c == 5) begin
                checks++;
                if (S !== 32'h0000_0000 || COUT !== 1'b1) begin
                    failures++;
                    $display("FAIL bubble_second: got c=%b s=%h expected c=1 s=00000000", COUT, S);
                end
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'h0101_0101 * (c + 1), 32'h7000_0000, 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        RSTN = 1'b0;
        tick();
        RSTN = 1'b1;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if ({OUT_VALID, COUT, S} !== 34'h0) begin
                failures++;
                $display("FAIL midreset_quiet cyc%0d: got v=%b c=%b s=%h expected all zero", c, OUT_VALID, COUT, S);
            end
            tick();
        end
        // Fresh operation after the reset still flows normally.
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);
            else        drive(1'b0, 32'h0, 32'h0, 1'b0);
            tick();
            checks++;
            if (OUT_VALID !== (c == 3)) begin
                failures++;
                $display("FAIL midreset_new_valid cyc%0d: got %b expected %b", c, OUT_VALID, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (S !== 32'h0000_0002 || COUT !== 1'b0) begin
                    failures++;
                    $display("FAIL midreset_new_sum: got c=%b s=%h expected c=0 s=00000002", COUT, S);
                end
            end
        end
    endtask

    initial begin
        RSTN = 1'b0;
        EN   = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        test_reset();
        test_full_ripple();
        test_back_to_back();
        test_stall();
        test_bubble();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
